core_alu_reg: RTL and testbench
===============================

CORE_ALU_REG -- requirements
Module: core_alu_reg

Interface
REQ-001 SHALL have parameter RESET_VALUE, default 8'h00, giving the reset value of Q_result.
REQ-002 SHALL have port I_clock, input, 1 bit; the single clock, and all state updates on its rising edge.
REQ-003 SHALL have port I_reset, input, 1 bit; synchronous, active-low reset.
REQ-004 SHALL have port I_enable, input, 1 bit; capture strobe for the output registers.
REQ-005 SHALL have port I_control, input, 4 bits; operation select per REQ-011.
REQ-006 SHALL have port I_mask_p, input, 1 bit; 1 lets the operation update the flags, 0 forces all flag outputs to equal the flag inputs.
REQ-007 SHALL have ports I_lhs and I_rhs, inputs, 8 bits each; the operands.
REQ-008 SHALL have ports I_carry, I_overflow, I_sign and I_zero, inputs, 1 bit each; the current C, V, N and Z flags.
REQ-009 SHALL have ports O_result (8 bits), O_carry, O_overflow, O_sign and O_zero (1 bit each), outputs; combinational result and flags.
REQ-010 SHALL have ports Q_result (8 bits) and Q_flags (4 bits, ordered {N,V,Z,C}), outputs; registered copies of the combinational outputs.

Function
REQ-011 SHALL decode I_control as: 0 NOP, 1 ADC, 2 SBC, 3 CMP, 4 AND, 5 ORA, 6 EOR, 7 ASL, 8 LSR, 9 ROL, 10 ROR, 11 INC, 12 DEC, 13 BIT, 14 LD, 15 reserved (behaves as NOP).
REQ-012 SHALL, for any flag not listed for an operation, pass the flag input through to the matching flag output.
REQ-013 NOP SHALL give result=lhs with all flags passed through.
REQ-014 ADC SHALL compute the 9-bit sum lhs+rhs+carry, binary only (no decimal mode): result=sum[7:0], C=sum[8], V=(lhs[7]==rhs[7])&&(result[7]!=lhs[7]), and N, Z updated.
REQ-015 SBC SHALL behave as ADC with rhs replaced by ~rhs (borrow = ~carry).
REQ-016 CMP SHALL compute lhs+~rhs+1, leave result=lhs, set C=(lhs>=rhs unsigned), set N and Z from the difference, and leave V unchanged.
REQ-017 AND, ORA and EOR SHALL compute the bitwise op of lhs and rhs and update N and Z.
REQ-018 ASL SHALL shift lhs left, shifting in 0, with C=lhs[7].
REQ-019 LSR SHALL shift lhs right, shifting in 0, with C=lhs[0], so N=0.
REQ-020 ROL SHALL shift lhs left, shifting in carry, with C=lhs[7].
REQ-021 ROR SHALL shift lhs right, shifting carry into bit 7, with C=lhs[0].
REQ-022 All four shift operations (ASL, LSR, ROL, ROR) SHALL update N and Z.
REQ-023 INC and DEC SHALL compute lhs±1 modulo 256 (FF+1=00, 00-1=FF), update N and Z, and leave C and V unchanged.
REQ-024 BIT SHALL leave result=lhs and set Z=((lhs&rhs)==0), N=rhs[7] and V=rhs[6].
REQ-025 LD SHALL give result=rhs and update N and Z.
REQ-026 Wherever N and Z are "updated", N SHALL be result[7] (difference[7] for CMP) and Z SHALL be (result==0) (difference==0 for CMP).
REQ-027 I_mask_p=0 SHALL leave O_result unaffected and override only the flag outputs.
REQ-028 The combinational path SHALL have zero latency and contain no latches; the outputs SHALL be fully defined for every I_control code.
REQ-029 On a rising I_clock edge with I_reset=1 and I_enable=1, Q_result SHALL load O_result and Q_flags SHALL load {O_sign,O_overflow,O_zero,O_carry}.
REQ-030 On a rising I_clock edge with I_reset=1 and I_enable=0, Q_result and Q_flags SHALL hold their values.
REQ-031 Reset SHALL take priority over I_enable.

Reset
REQ-032 On a rising I_clock edge with I_reset=0, Q_result SHALL become RESET_VALUE and Q_flags SHALL become 4'b0000.
REQ-033 Reset SHALL have no effect between clock edges, and the combinational outputs SHALL be unaffected by reset.
REQ-034 Asserting reset mid-sequence SHALL discard any pending capture in that cycle.

Verification
REQ-035 ADC with lhs=50, rhs=50, C=0 -> result=A0, C=0, V=1, N=1, Z=0; then ADC with lhs=FF, rhs=01, C=0 -> result=00, C=1, Z=1, V=0.
REQ-036 SBC with lhs=50, rhs=F0, C=1 -> result=60, C=0, V=0; CMP with lhs=10, rhs=10 -> result=10, C=1, Z=1, N=0, V unchanged.
REQ-037 ROR with lhs=01, C=1 -> result=80, C=1, N=1; LSR with lhs=01 -> result=00, C=1, Z=1, N=0.
REQ-038 BIT with lhs=0F, rhs=C0 -> Z=1, N=1, V=1, result=0F; INC of FF -> 00, Z=1, with C unchanged.
REQ-039 I_mask_p=0 with ADC FF+01 and input flags C=0, Z=0 -> result=00 and all flags equal the inputs.
REQ-040 Register check: hold I_reset=0 for one edge -> Q_result=RESET_VALUE and Q_flags=0; then with I_enable=0 and new inputs -> Q holds; then with I_enable=1 -> Q captures on the next edge; then assert reset while I_enable=1 -> reset value wins.

Source files
------------

// File: rtl/core_alu_reg_if.sv
// core_alu_reg_if: operand/flag inputs, combinational outputs and registered outputs of core_alu_reg
//    I_enable            capture strobe for the output registers
//    I_control[3:0]      operation select
//    I_mask_p            1 lets the operation update flags, 0 passes flag inputs through
//    I_lhs, I_rhs        8-bit operands
//    I_carry/I_overflow/I_sign/I_zero   incoming C, V, N, Z
//    O_result, O_carry/O_overflow/O_sign/O_zero   combinational result and flags
//    Q_result, Q_flags{N,V,Z,C}                   registered copies
interface core_alu_reg_if;
   logic       I_enable;
   logic [3:0] I_control;
   logic       I_mask_p;
   logic [7:0] I_lhs;
   logic [7:0] I_rhs;
   logic       I_carry;
   logic       I_overflow;
   logic       I_sign;
   logic       I_zero;
   logic [7:0] O_result;
   logic       O_carry;
   logic       O_overflow;
   logic       O_sign;
   logic       O_zero;
   logic [7:0] Q_result;
   logic [3:0] Q_flags;
   modport master (
      output I_enable, I_control, I_mask_p, I_lhs, I_rhs, I_carry, I_overflow, I_sign, I_zero,
      input  O_result, O_carry, O_overflow, O_sign, O_zero, Q_result, Q_flags
   );
   modport slave (
      input  I_enable, I_control, I_mask_p, I_lhs, I_rhs, I_carry, I_overflow, I_sign, I_zero,
      output O_result, O_carry, O_overflow, O_sign, O_zero, Q_result, Q_flags
   );
endinterface

// File: rtl/core_alu_reg.sv
// core_alu_reg: 8-bit 6502-style ALU with combinational result/flags and an enabled output register
//    I_clock   rising-edge clock
//    I_reset   synchronous active-low reset of Q_result/Q_flags
//    bus       core_alu_reg_if.slave carrying operands, flags, strobe and all outputs
module core_alu_reg #(
   parameter logic [7:0] RESET_VALUE = 8'h00
) (
   input logic          I_clock,
   input logic          I_reset,
   core_alu_reg_if.slave bus
);
   typedef enum logic [3:0] {
      OP_NOP, OP_ADC, OP_SBC, OP_CMP, OP_AND, OP_ORA, OP_EOR, OP_ASL,
      OP_LSR, OP_ROL, OP_ROR, OP_INC, OP_DEC, OP_BIT, OP_LD, OP_RSV
   } op_e;
   op_e        op;
   logic [7:0] addend;
   logic [8:0] sum;
   logic [7:0] res;
   logic [7:0] nz_src;
   logic       c;
   logic       v;
   logic       n;
   logic       z;
   logic       upd;
   assign op = op_e'(bus.I_control);
   always_comb begin
      // one adder serves ADC, SBC and CMP; CMP forces carry-in so it is a true subtract
      addend = (op == OP_ADC) ? bus.I_rhs : ~bus.I_rhs;
      sum    = {1'b0, bus.I_lhs} + {1'b0, addend} + {8'd0, (op == OP_CMP) | bus.I_carry};
      res    = bus.I_lhs;
      c      = bus.I_carry;
      v      = bus.I_overflow;
      upd    = 1'b1;
      case (op)
         OP_ADC, OP_SBC: begin
            res = sum[7:0];
            c   = sum[8];
            v   = (bus.I_lhs[7] == addend[7]) && (sum[7] != bus.I_lhs[7]);
         end
         OP_CMP: c = sum[8];
         OP_AND: res = bus.I_lhs & bus.I_rhs;
         OP_ORA: res = bus.I_lhs | bus.I_rhs;
         OP_EOR: res = bus.I_lhs ^ bus.I_rhs;
         OP_ASL: {c, res} = {bus.I_lhs, 1'b0};
         OP_LSR: {res, c} = {1'b0, bus.I_lhs};
         OP_ROL: {c, res} = {bus.I_lhs, bus.I_carry};
         OP_ROR: {res, c} = {bus.I_carry, bus.I_lhs};
         OP_INC: res = bus.I_lhs + 8'd1;
         OP_DEC: res = bus.I_lhs - 8'd1;
         OP_BIT: begin
            v   = bus.I_rhs[6];
            upd = 1'b0;
         end
         OP_LD:  res = bus.I_rhs;
         default: upd = 1'b0;
      endcase
      // CMP reports N/Z of the difference while its result stays lhs
      nz_src = (op == OP_CMP) ? sum[7:0] : res;
      n = (op == OP_BIT) ? bus.I_rhs[7] : upd ? nz_src[7] : bus.I_sign;
      z = (op == OP_BIT) ? ((bus.I_lhs & bus.I_rhs) == 8'd0) : upd ? (nz_src == 8'd0) : bus.I_zero;
   end
   assign bus.O_result   = res;
   assign bus.O_carry    = bus.I_mask_p ? c : bus.I_carry;
   assign bus.O_overflow = bus.I_mask_p ? v : bus.I_overflow;
   assign bus.O_sign     = bus.I_mask_p ? n : bus.I_sign;
   assign bus.O_zero     = bus.I_mask_p ? z : bus.I_zero;
   always_ff @(posedge I_clock) begin
      if (!I_reset) begin
         bus.Q_result <= RESET_VALUE;
         bus.Q_flags  <= 4'b0000;
      end else if (bus.I_enable) begin
         bus.Q_result <= bus.O_result;
         bus.Q_flags  <= {bus.O_sign, bus.O_overflow, bus.O_zero, bus.O_carry};
      end
   end
endmodule

// File: tb/tb_core_alu_reg.sv
// tb_core_alu_reg: directed and pseudo-random checks of core_alu_reg against an arithmetic reference model
module tb_core_alu_reg;
   localparam logic [7:0] RV = 8'hA5;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   logic        q_known = 1'b0;
   logic [11:0] exp_q;
   core_alu_reg_if bus ();
   core_alu_reg #(.RESET_VALUE(RV)) dut (.I_clock(clk), .I_reset(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   // returns {result, N, V, Z, C} computed with plain integer arithmetic
   function automatic logic [11:0] model(input logic [3:0] ctl, input logic m, input logic [7:0] a,
                                         input logic [7:0] b, input logic [3:0] f);
      int   r, s, sa, sb, ci;
      logic n, v, z, c, upd;
      logic [7:0] rr;
      n = f[3]; v = f[2]; z = f[1]; c = f[0];
      ci = int'(f[0]);
      sa = (int'(a) > 127) ? int'(a) - 256 : int'(a);
      sb = (int'(b) > 127) ? int'(b) - 256 : int'(b);
      r = int'(a);
      upd = 1'b1;
      case (ctl)
         4'd1: begin
            s = int'(a) + int'(b) + ci; r = s % 256; c = (s > 255);
            s = sa + sb + ci; v = (s > 127) || (s < -128);
         end
         4'd2: begin
            s = int'(a) - int'(b) - (1 - ci); r = (s + 256) % 256; c = (s >= 0);
            s = sa - sb - (1 - ci); v = (s > 127) || (s < -128);
         end
         4'd3: begin
            s = (int'(a) - int'(b) + 256) % 256;
            c = (a >= b); n = (s >= 128); z = (s == 0); upd = 1'b0;
         end
         4'd4: r = int'(a & b);
         4'd5: r = int'(a | b);
         4'd6: r = int'(a ^ b);
         4'd7: begin r = (int'(a) * 2) % 256; c = (int'(a) >= 128); end
         4'd8: begin r = int'(a) / 2; c = (int'(a) % 2 == 1); end
         4'd9: begin r = (int'(a) * 2 + ci) % 256; c = (int'(a) >= 128); end
         4'd10: begin r = int'(a) / 2 + 128 * ci; c = (int'(a) % 2 == 1); end
         4'd11: r = (int'(a) + 1) % 256;
         4'd12: r = (int'(a) + 255) % 256;
         4'd13: begin z = ((a & b) == 8'd0); n = (int'(b) >= 128); v = ((int'(b) / 64) % 2 == 1); upd = 1'b0; end
         4'd14: r = int'(b);
         default: upd = 1'b0;
      endcase
      if (upd) begin n = (r >= 128); z = (r == 0); end
      if (!m) {n, v, z, c} = f;
      rr = r[7:0];
      return {rr, n, v, z, c};
   endfunction
   always @(posedge clk) begin
      if (!rst) begin
         exp_q   <= {RV, 4'b0000};
         q_known <= 1'b1;
      end else if (bus.I_enable)
         exp_q <= model(bus.I_control, bus.I_mask_p, bus.I_lhs, bus.I_rhs,
                        {bus.I_sign, bus.I_overflow, bus.I_zero, bus.I_carry});
   end
   always @(negedge clk) begin
      check("comb_vs_model", {bus.O_result, bus.O_sign, bus.O_overflow, bus.O_zero, bus.O_carry},
            model(bus.I_control, bus.I_mask_p, bus.I_lhs, bus.I_rhs,
                  {bus.I_sign, bus.I_overflow, bus.I_zero, bus.I_carry}));
      if (q_known) check("qreg_vs_model", {bus.Q_result, bus.Q_flags}, exp_q);
   end
   task automatic drive(input logic r, input logic en, input logic [3:0] ctl, input logic m,
                        input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
      rst = r;
      bus.I_enable = en; bus.I_control = ctl; bus.I_mask_p = m;
      bus.I_lhs = a; bus.I_rhs = b;
      {bus.I_sign, bus.I_overflow, bus.I_zero, bus.I_carry} = f;
   endtask
   task automatic run_vec(input string nm, input logic [3:0] ctl, input logic m, input logic [7:0] a,
                          input logic [7:0] b, input logic [3:0] f, input logic [7:0] er, input logic [3:0] ef);
      #1 drive(1'b1, 1'b0, ctl, m, a, b, f);
      @(negedge clk);
      check(nm, {bus.O_result, bus.O_sign, bus.O_overflow, bus.O_zero, bus.O_carry}, {er, ef});
   endtask
   initial begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 8'h00, 8'h00, 4'h0);
      @(negedge clk);
      check("reset_q", {bus.Q_result, bus.Q_flags}, {RV, 4'h0});
      run_vec("adc_50_50",   4'd1,  1'b1, 8'h50, 8'h50, 4'b0000, 8'hA0, 4'b1100);
      run_vec("adc_ff_01",   4'd1,  1'b1, 8'hFF, 8'h01, 4'b0000, 8'h00, 4'b0011);
      run_vec("adc_7f_c",    4'd1,  1'b1, 8'h7F, 8'h00, 4'b0001, 8'h80, 4'b1100);
      run_vec("sbc_50_f0",   4'd2,  1'b1, 8'h50, 8'hF0, 4'b0001, 8'h60, 4'b0000);
      run_vec("sbc_00_01",   4'd2,  1'b1, 8'h00, 8'h01, 4'b0001, 8'hFF, 4'b1000);
      run_vec("cmp_10_10",   4'd3,  1'b1, 8'h10, 8'h10, 4'b0100, 8'h10, 4'b0111);
      run_vec("and_f0_3c",   4'd4,  1'b1, 8'hF0, 8'h3C, 4'b0000, 8'h30, 4'b0000);
      run_vec("ora_zero",    4'd5,  1'b1, 8'h00, 8'h00, 4'b0001, 8'h00, 4'b0011);
      run_vec("eor_aa_aa",   4'd6,  1'b1, 8'hAA, 8'hAA, 4'b0000, 8'h00, 4'b0010);
      run_vec("asl_80",      4'd7,  1'b1, 8'h80, 8'h00, 4'b0000, 8'h00, 4'b0011);
      run_vec("lsr_01",      4'd8,  1'b1, 8'h01, 8'h00, 4'b0000, 8'h00, 4'b0011);
      run_vec("rol_80_c",    4'd9,  1'b1, 8'h80, 8'h00, 4'b0001, 8'h01, 4'b0001);
      run_vec("ror_01_c",    4'd10, 1'b1, 8'h01, 8'h00, 4'b0001, 8'h80, 4'b1001);
      run_vec("inc_ff",      4'd11, 1'b1, 8'hFF, 8'h00, 4'b0001, 8'h00, 4'b0011);
      run_vec("dec_00",      4'd12, 1'b1, 8'h00, 8'h00, 4'b0000, 8'hFF, 4'b1000);
      run_vec("bit_0f_c0",   4'd13, 1'b1, 8'h0F, 8'hC0, 4'b0000, 8'h0F, 4'b1110);
      run_vec("ld_00",       4'd14, 1'b1, 8'h77, 8'h00, 4'b1000, 8'h00, 4'b0010);
      run_vec("nop_5a",      4'd0,  1'b1, 8'h5A, 8'h11, 4'b1101, 8'h5A, 4'b1101);
      run_vec("reserved_f",  4'd15, 1'b1, 8'h33, 8'h44, 4'b0010, 8'h33, 4'b0010);
      run_vec("mask_adc",    4'd1,  1'b0, 8'hFF, 8'h01, 4'b1000, 8'h00, 4'b1000);
      #1 drive(1'b0, 1'b0, 4'd0, 1'b1, 8'h00, 8'h00, 4'h0);
      @(negedge clk);
      check("reg_reset", {bus.Q_result, bus.Q_flags}, {RV, 4'h0});
      #1 drive(1'b1, 1'b0, 4'd1, 1'b1, 8'h50, 8'h50, 4'b0000);
      @(negedge clk);
      check("reg_hold", {bus.Q_result, bus.Q_flags}, {RV, 4'h0});
      #1 bus.I_enable = 1'b1;
      @(negedge clk);
      check("reg_capture", {bus.Q_result, bus.Q_flags}, {8'hA0, 4'b1100});
      #1 drive(1'b0, 1'b1, 4'd14, 1'b1, 8'h00, 8'h33, 4'b0000);
      @(negedge clk);
      check("reg_reset_wins", {bus.Q_result, bus.Q_flags}, {RV, 4'h0});
      #1 drive(1'b1, 1'b0, 4'd14, 1'b1, 8'h00, 8'h33, 4'b0000);
      @(negedge clk);
      check("reg_hold_after_reset", {bus.Q_result, bus.Q_flags}, {RV, 4'h0});
      for (int i = 0; i < 200; i++) begin
         #1 drive(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  4'($urandom_range(0, 15)));
         @(negedge clk);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
